// File: rtl/tug_match_ctrl.sv
// tug_match_ctrl: tug-of-war round/match sequencer with scoreboard digits; TUG_BLINK_EN blinks the winner digit in DONE.
module tug_match_ctrl #(
  parameter int WIN_ROUNDS  = 3,
  parameter int HOLD_CYCLES = 50
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       start,
  input  logic       win_l,
  input  logic       win_r,
  output logic       field_clr,
  output logic       play_en,
  output logic [2:0] score_l,
  output logic [2:0] score_r,
  output logic [6:0] HEX5,
  output logic [6:0] HEX4,
  output logic       match_done,
  output logic [1:0] winner
);
  typedef enum logic [2:0] {IDLE, CLEAR, PLAY, HOLD, DONE} state_t;
  localparam logic [15:0] LAST = 16'(HOLD_CYCLES - 1);
  localparam logic [2:0] WIN = 3'(WIN_ROUNDS);
  localparam logic [6:0] SEG [8] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                                    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000};
  state_t state, state_n;
  logic [15:0] cnt, cnt_n;
  logic [2:0] sl_n, sr_n;
  logic [1:0] win_n;
  logic blink, blink_n;
  assign field_clr  = state == CLEAR;
  assign play_en    = state == PLAY;
  assign match_done = state == DONE;
  // blink=1 is the dark phase; only meaningful while a winner is latched
  assign HEX5 = (blink && winner == 2'b01) ? 7'b1111111 : SEG[score_l];
  assign HEX4 = (blink && winner == 2'b10) ? 7'b1111111 : SEG[score_r];
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    sl_n    = score_l;
    sr_n    = score_r;
    win_n   = winner;
    blink_n = blink;
    case (state)
      IDLE, DONE: begin
        if (start) begin
          state_n = CLEAR;
          sl_n    = '0;
          sr_n    = '0;
          win_n   = '0;
          cnt_n   = '0;
          blink_n = 1'b0;
        end
`ifdef TUG_BLINK_EN
        else if (state == DONE) begin
          cnt_n   = (cnt == LAST) ? '0 : cnt + 16'd1;
          blink_n = (cnt == LAST) ? ~blink : blink;
        end
`endif
      end
      CLEAR: state_n = PLAY;
      PLAY: begin
        if (win_l || win_r) begin
          state_n = HOLD;
          cnt_n   = '0;
          sl_n    = (win_l && !win_r) ? score_l + 3'd1 : score_l;
          sr_n    = (win_r && !win_l) ? score_r + 3'd1 : score_r;
        end
      end
      HOLD: begin
        if (cnt == LAST) begin
          cnt_n   = '0;
          blink_n = 1'b0;
          state_n = (score_l == WIN || score_r == WIN) ? DONE : CLEAR;
          win_n   = (score_l == WIN) ? 2'b01 : (score_r == WIN) ? 2'b10 : 2'b00;
        end else begin
          cnt_n = cnt + 16'd1;
        end
      end
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state   <= IDLE;
      cnt     <= '0;
      score_l <= '0;
      score_r <= '0;
      winner  <= '0;
      blink   <= 1'b0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      score_l <= sl_n;
      score_r <= sr_n;
      winner  <= win_n;
      blink   <= blink_n;
    end
  end
endmodule
